// File: rtl/control_sequencer.sv
// Hardwired control FSM: fetch/decode/execute sequencing of the datapath strobes.
// Optional MFC wait timeout is enabled by defining CTRL_MFC_TIMEOUT_EN.
module control_sequencer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic        MFC,
  output logic        PCOutEn,
  output logic        PCInc,
  output logic        ALUin0,
  output logic        ALUin1,
  output logic        ALUOutLatch,
  output logic        ALUOutEn,
  output logic [2:0]  opControl,
  output logic        r0Latch,
  output logic        r1Latch,
  output logic        r2Latch,
  output logic        r3Latch,
  output logic        r0Out,
  output logic        r1Out,
  output logic        r2Out,
  output logic        r3Out,
  output logic        memEN,
  output logic        memRW,
  output logic        MARin,
  output logic        MDRwriteEN,
  output logic        MDRreadEN,
  output logic        MDRout,
  output logic        p0Latch,
  output logic        p0Out,
  output logic        p1Latch,
  output logic        p1Out,
  output logic        IREN,
  output logic        halted,
  output logic        fault
);

  typedef enum logic [4:0] {
    S_IDLE, S_F0, S_F1, S_F2, S_F3, S_DEC,
    S_A0, S_A1, S_A2, S_A3,
    S_L0, S_L1, S_L2, S_L3,
    S_S0, S_S1, S_S2,
    S_O0, S_I0, S_HALT, S_FAULT
  } state_t;

  typedef struct packed {
    logic       pc_out;
    logic       pc_inc;
    logic       alu_in0;
    logic       alu_in1;
    logic       alu_latch;
    logic       alu_out;
    logic [3:0] r_latch;
    logic [3:0] r_out;
    logic       mem_en;
    logic       mem_rw;
    logic       mar_in;
    logic       mdr_wr;
    logic       mdr_rd;
    logic       mdr_out;
    logic       p0_latch;
    logic       p0_out;
    logic       p1_latch;
    logic       p1_out;
    logic       ir_en;
    logic       halted;
  } ctl_t;

  state_t r_state;
  state_t w_next;
  ctl_t   r_ctl;
  ctl_t   w_ctl;
  logic   w_timeout;
  logic   w_unused_ir;

  // Strobes belonging to a state; registered against the next state so they are
  // glitch-free and line up with the state they describe.
  function automatic ctl_t decode(input state_t s, input logic [15:0] ir_v);
    ctl_t c;
    c = '0;
    case (s)
      S_F0:   begin c.pc_out = 1'b1; c.mar_in = 1'b1; end
      S_F1:   begin c.mem_en = 1'b1; c.mem_rw = 1'b1; end
      S_F2:   c.mdr_rd = 1'b1;
      S_F3:   begin c.mdr_out = 1'b1; c.ir_en = 1'b1; c.pc_inc = 1'b1; end
      S_A0:   begin c.r_out = 4'b0001 << ir_v[9:8]; c.alu_in0 = 1'b1; end
      S_A1:   begin c.r_out = 4'b0001 << ir_v[7:6]; c.alu_in1 = 1'b1; end
      S_A2:   c.alu_latch = 1'b1;
      S_A3:   begin c.alu_out = 1'b1; c.r_latch = 4'b0001 << ir_v[11:10]; end
      S_L0:   begin c.r_out = 4'b0001 << ir_v[9:8]; c.mar_in = 1'b1; end
      S_L1:   begin c.mem_en = 1'b1; c.mem_rw = 1'b1; end
      S_L2:   c.mdr_rd = 1'b1;
      S_L3:   begin c.mdr_out = 1'b1; c.r_latch = 4'b0001 << ir_v[11:10]; end
      S_S0:   begin c.r_out = 4'b0001 << ir_v[9:8]; c.mar_in = 1'b1; end
      S_S1:   begin c.r_out = 4'b0001 << ir_v[11:10]; c.mdr_wr = 1'b1; end
      S_S2:   c.mem_en = 1'b1;
      S_O0:   begin c.r_out = 4'b0001 << ir_v[9:8]; c.p0_latch = 1'b1; end
      S_I0:   begin c.p1_out = 1'b1; c.r_latch = 4'b0001 << ir_v[11:10]; end
      S_HALT: c.halted = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

`ifdef CTRL_MFC_TIMEOUT_EN
  logic [7:0] r_wait;
  logic       r_fault;
  logic       w_wait_state;

  assign w_wait_state = (r_state == S_F1) || (r_state == S_L1) || (r_state == S_S2);
  assign w_timeout    = w_wait_state && !MFC && (r_wait == 8'(TIMEOUT_CYCLES - 1));

  // Counter is held at zero outside the wait states, so every wait starts from 0
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait  <= '0;
      r_fault <= 1'b0;
    end else begin
      r_fault <= (w_next == S_FAULT);
      if (!w_wait_state)
        r_wait <= '0;
      else if (!MFC)
        r_wait <= r_wait + 8'd1;
    end
  end

  assign fault = r_fault;
`else
  logic [7:0] w_unused_timeout;
  assign w_unused_timeout = 8'(TIMEOUT_CYCLES);
  assign w_timeout        = 1'b0;
  assign fault            = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: w_next = S_F0;
      S_F0:   w_next = S_F1;
      S_F1:   if (MFC) w_next = S_F2; else if (w_timeout) w_next = S_FAULT;
      S_F2:   w_next = S_F3;
      S_F3:   w_next = S_DEC;
      S_DEC: begin
        if (!ir[15]) w_next = S_A0;
        else begin
          case (ir[14:12])
            3'b000:  w_next = S_L0;
            3'b001:  w_next = S_S0;
            3'b010:  w_next = S_O0;
            3'b011:  w_next = S_I0;
            3'b100:  w_next = S_HALT;
            default: w_next = S_F0;
          endcase
        end
      end
      S_A0:   w_next = S_A1;
      S_A1:   w_next = S_A2;
      S_A2:   w_next = S_A3;
      S_A3:   w_next = S_F0;
      S_L0:   w_next = S_L1;
      S_L1:   if (MFC) w_next = S_L2; else if (w_timeout) w_next = S_FAULT;
      S_L2:   w_next = S_L3;
      S_L3:   w_next = S_F0;
      S_S0:   w_next = S_S1;
      S_S1:   w_next = S_S2;
      S_S2:   if (MFC) w_next = S_F0; else if (w_timeout) w_next = S_FAULT;
      S_O0:   w_next = S_F0;
      S_I0:   w_next = S_F0;
      S_HALT: w_next = S_HALT;
      S_FAULT: w_next = S_FAULT;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_ctl = decode(w_next, ir);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ctl   <= '0;
    end else begin
      r_state <= w_next;
      r_ctl   <= w_ctl;
    end
  end

  assign w_unused_ir = ^ir[5:0];
  assign opControl   = ir[14:12];
  assign PCOutEn     = r_ctl.pc_out;
  assign PCInc       = r_ctl.pc_inc;
  assign ALUin0      = r_ctl.alu_in0;
  assign ALUin1      = r_ctl.alu_in1;
  assign ALUOutLatch = r_ctl.alu_latch;
  assign ALUOutEn    = r_ctl.alu_out;
  assign r0Latch     = r_ctl.r_latch[0];
  assign r1Latch     = r_ctl.r_latch[1];
  assign r2Latch     = r_ctl.r_latch[2];
  assign r3Latch     = r_ctl.r_latch[3];
  assign r0Out       = r_ctl.r_out[0];
  assign r1Out       = r_ctl.r_out[1];
  assign r2Out       = r_ctl.r_out[2];
  assign r3Out       = r_ctl.r_out[3];
  assign memEN       = r_ctl.mem_en;
  assign memRW       = r_ctl.mem_rw;
  assign MARin       = r_ctl.mar_in;
  assign MDRwriteEN  = r_ctl.mdr_wr;
  assign MDRreadEN   = r_ctl.mdr_rd;
  assign MDRout      = r_ctl.mdr_out;
  assign p0Latch     = r_ctl.p0_latch;
  assign p0Out       = r_ctl.p0_out;
  assign p1Latch     = r_ctl.p1_latch;
  assign p1Out       = r_ctl.p1_out;
  assign IREN        = r_ctl.ir_en;
  assign halted      = r_ctl.halted;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-cycle strobe sequences predicted from the
// instruction set description, with random instructions, waits and MFC noise.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] ir  = 16'h0000;
  logic        MFC = 1'b0;
  logic PCOutEn, PCInc, ALUin0, ALUin1, ALUOutLatch, ALUOutEn;
  logic [2:0] opControl;
  logic r0Latch, r1Latch, r2Latch, r3Latch, r0Out, r1Out, r2Out, r3Out;
  logic memEN, memRW, MARin, MDRwriteEN, MDRreadEN, MDRout;
  logic p0Latch, p0Out, p1Latch, p1Out, IREN, halted, fault;

  control_sequencer #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .ir(ir), .MFC(MFC),
    .PCOutEn(PCOutEn), .PCInc(PCInc), .ALUin0(ALUin0), .ALUin1(ALUin1),
    .ALUOutLatch(ALUOutLatch), .ALUOutEn(ALUOutEn), .opControl(opControl),
    .r0Latch(r0Latch), .r1Latch(r1Latch), .r2Latch(r2Latch), .r3Latch(r3Latch),
    .r0Out(r0Out), .r1Out(r1Out), .r2Out(r2Out), .r3Out(r3Out),
    .memEN(memEN), .memRW(memRW), .MARin(MARin), .MDRwriteEN(MDRwriteEN),
    .MDRreadEN(MDRreadEN), .MDRout(MDRout), .p0Latch(p0Latch), .p0Out(p0Out),
    .p1Latch(p1Latch), .p1Out(p1Out), .IREN(IREN), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  localparam logic [26:0] M_NONE   = 27'd0;
  localparam logic [26:0] M_FAULT  = 27'd1 << 0;
  localparam logic [26:0] M_HALTED = 27'd1 << 1;
  localparam logic [26:0] M_IREN   = 27'd1 << 2;
  localparam logic [26:0] M_P1OUT  = 27'd1 << 3;
  localparam logic [26:0] M_P0LAT  = 27'd1 << 6;
  localparam logic [26:0] M_MDROUT = 27'd1 << 7;
  localparam logic [26:0] M_MDRRD  = 27'd1 << 8;
  localparam logic [26:0] M_MDRWR  = 27'd1 << 9;
  localparam logic [26:0] M_MARIN  = 27'd1 << 10;
  localparam logic [26:0] M_MEMRW  = 27'd1 << 11;
  localparam logic [26:0] M_MEMEN  = 27'd1 << 12;
  localparam logic [26:0] M_ALUOUT = 27'd1 << 21;
  localparam logic [26:0] M_ALULAT = 27'd1 << 22;
  localparam logic [26:0] M_ALUIN1 = 27'd1 << 23;
  localparam logic [26:0] M_ALUIN0 = 27'd1 << 24;
  localparam logic [26:0] M_PCINC  = 27'd1 << 25;
  localparam logic [26:0] M_PCOUT  = 27'd1 << 26;

  typedef struct {
    logic [26:0] v;
    logic        m;
    logic [15:0] i;
  } ent_t;

  ent_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [26:0] reg_out(input logic [1:0] n);
    return 27'd1 << (13 + int'(n));
  endfunction

  function automatic logic [26:0] reg_lat(input logic [1:0] n);
    return 27'd1 << (17 + int'(n));
  endfunction

  function automatic logic [26:0] obs();
    return {PCOutEn, PCInc, ALUin0, ALUin1, ALUOutLatch, ALUOutEn,
            r3Latch, r2Latch, r1Latch, r0Latch, r3Out, r2Out, r1Out, r0Out,
            memEN, memRW, MARin, MDRwriteEN, MDRreadEN, MDRout,
            p0Latch, p0Out, p1Latch, p1Out, IREN, halted, fault};
  endfunction

  task automatic push(input logic [26:0] v, input logic m, input logic [15:0] i);
    ent_t e;
    e.v = v; e.m = m; e.i = i;
    q.push_back(e);
  endtask

  // MFC is random where it must be ignored; low for w cycles then high in waits
  task automatic push_wait(input logic [26:0] v, input int w, input logic [15:0] i);
    for (int j = 0; j <= w; j++) push(v, (j == w), i);
  endtask

  task automatic build_instr(input logic [15:0] x, input int w1, input int w2);
    logic [1:0] rd, ra, rb;
    rd = x[11:10]; ra = x[9:8]; rb = x[7:6];
    push(M_PCOUT | M_MARIN, 1'($urandom_range(0, 1)), x);
    push_wait(M_MEMEN | M_MEMRW, w1, x);
    push(M_MDRRD, 1'($urandom_range(0, 1)), x);
    push(M_MDROUT | M_IREN | M_PCINC, 1'($urandom_range(0, 1)), x);
    push(M_NONE, 1'($urandom_range(0, 1)), x);
    if (!x[15]) begin
      push(reg_out(ra) | M_ALUIN0, 1'($urandom_range(0, 1)), x);
      push(reg_out(rb) | M_ALUIN1, 1'($urandom_range(0, 1)), x);
      push(M_ALULAT, 1'($urandom_range(0, 1)), x);
      push(M_ALUOUT | reg_lat(rd), 1'($urandom_range(0, 1)), x);
    end else begin
      case (x[14:12])
        3'd0: begin
          push(reg_out(ra) | M_MARIN, 1'($urandom_range(0, 1)), x);
          push_wait(M_MEMEN | M_MEMRW, w2, x);
          push(M_MDRRD, 1'($urandom_range(0, 1)), x);
          push(M_MDROUT | reg_lat(rd), 1'($urandom_range(0, 1)), x);
        end
        3'd1: begin
          push(reg_out(ra) | M_MARIN, 1'($urandom_range(0, 1)), x);
          push(reg_out(rd) | M_MDRWR, 1'($urandom_range(0, 1)), x);
          push_wait(M_MEMEN, w2, x);
        end
        3'd2: push(reg_out(ra) | M_P0LAT, 1'($urandom_range(0, 1)), x);
        3'd3: push(M_P1OUT | reg_lat(rd), 1'($urandom_range(0, 1)), x);
        default: ;
      endcase
    end
  endtask

  task automatic run_n(input string name, input int n);
    ent_t e;
    for (int k = 0; k < n && q.size() > 0; k++) begin
      e = q.pop_front();
      @(negedge clk);
      ir  = e.i;
      MFC = e.m;
      #1;
      n_checks++;
      if (obs() !== e.v) begin
        n_fail++;
        $display("FAIL %s step %0d strobes: got %h expected %h", name, k, obs(), e.v);
      end
      n_checks++;
      if (opControl !== e.i[14:12]) begin
        n_fail++;
        $display("FAIL %s step %0d opControl: got %b expected %b", name, k, opControl, e.i[14:12]);
      end
    end
  endtask

  task automatic run_all(input string name);
    run_n(name, q.size());
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; MFC = 1'b0; ir = 16'h0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic check_idle(input string name);
    n_checks++;
    if (obs() !== M_NONE) begin
      n_fail++;
      $display("FAIL %s idle strobes: got %h expected %h", name, obs(), M_NONE);
    end
    n_checks++;
    if (opControl !== 3'b000) begin
      n_fail++;
      $display("FAIL %s idle opControl: got %b expected 000", name, opControl);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_idle("reset");
    n_checks++;
    if (halted !== 1'b0 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL reset flags: got halted=%b fault=%b expected 0 0", halted, fault);
    end
    push(M_PCOUT | M_MARIN, 1'b0, 16'h0000);
    run_all("reset_f0");
  endtask

  task automatic test_directed();
    do_reset();
    build_instr(16'h1640, 0, 0);
    build_instr(16'h8300, 0, 3);
    build_instr(16'h9900, 0, 0);
    build_instr(16'h5FC0, 1, 0);
    push(M_PCOUT | M_MARIN, 1'b1, 16'h0000);
    run_all("directed");
  endtask

  task automatic test_back_to_back();
    do_reset();
    build_instr(16'hA200, 2, 0);
    build_instr(16'hB800, 0, 0);
    build_instr(16'hD000, 0, 0);
    build_instr(16'hF000, 1, 0);
    build_instr(16'h9C00, 0, 2);
    build_instr(16'h2E40, 0, 0);
    push(M_PCOUT | M_MARIN, 1'b0, 16'h0000);
    run_all("b2b");
  endtask

  task automatic test_random();
    logic [15:0] x;
    do_reset();
    for (int k = 0; k < 30; k++) begin
      x = 16'($urandom);
      if (x[15] && x[14:12] == 3'd4) x[12] = 1'b1;
      build_instr(x, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    push(M_PCOUT | M_MARIN, 1'b0, 16'h0000);
    run_all("random");
  endtask

  task automatic test_halt();
    do_reset();
    build_instr(16'hC000, 1, 0);
    for (int k = 0; k < 20; k++) push(M_HALTED, 1'($urandom_range(0, 1)), 16'hC000);
    run_all("halt");
    do_reset();
    check_idle("halt_reset");
    push(M_PCOUT | M_MARIN, 1'b0, 16'h0000);
    run_all("halt_restart");
  endtask

  task automatic test_mid_reset();
    do_reset();
    build_instr(16'h8100, 0, 5);
    run_n("mid_reset", 8);
    q.delete();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle("mid_reset");
    push(M_PCOUT | M_MARIN, 1'b0, 16'h0000);
    run_all("mid_restart");
  endtask

  task automatic test_timeout();
    do_reset();
    push(M_PCOUT | M_MARIN, 1'b0, 16'h0000);
`ifdef CTRL_MFC_TIMEOUT_EN
    for (int k = 0; k < 4; k++) push(M_MEMEN | M_MEMRW, 1'b0, 16'h0000);
    for (int k = 0; k < 8; k++) push(M_FAULT, 1'($urandom_range(0, 1)), 16'h0000);
`else
    for (int k = 0; k < 40; k++) push(M_MEMEN | M_MEMRW, 1'b0, 16'h0000);
`endif
    run_all("timeout");
    do_reset();
    check_idle("timeout_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_halt();
    test_mid_reset();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control FSM that drives the microcontroller datapath's strobes: the tri-state enables, register latches, PC, memory/MAR/MDR, the I/O ports and the IR. It fetches each instruction over the shared 16-bit bus, decodes the IR and sequences the execute micro-steps. It waits on the memory handshake (`MFC`) for every memory access. It sits beside the datapath top level and connects to its control inputs one-for-one.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: MFC wait limit in cycles; used only when `CTRL_MFC_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous reset, active-high.
- `ir`  in  16  IR contents from the datapath.
- `MFC`  in  1  memory function complete, level.
- `PCOutEn`, `PCInc`  out  1 each  PC drives the bus; one-cycle PC increment pulse.
- `ALUin0`, `ALUin1`, `ALUOutLatch`, `ALUOutEn`  out  1 each  ALU operand latches; result latch; result bus drive.
- `opControl`  out  3  ALU op, equal to `ir[14:12]`.
- `r0Latch`..`r3Latch`, `r0Out`..`r3Out`  out  1 each  GP register latch and bus drive.
- `memEN`, `memRW`  out  1 each  memory enable; `memRW` 1 = read, 0 = write.
- `MARin`, `MDRwriteEN`, `MDRreadEN`, `MDRout`  out  1 each  MAR and MDR strobes.
- `p0Latch`, `p0Out`, `p1Latch`, `p1Out`  out  1 each  I/O port strobes.
- `IREN`  out  1  IR latch.
- `halted`  out  1  high while in HALT.
- `fault`  out  1  high while in FAULT.

## Operation
- Instruction format:
  - `ir[15]`=0 is ALU type: `ir[14:12]` op, `ir[11:10]` rd, `ir[9:8]` ra, `ir[7:6]` rb.
  - `ir[15]`=1 is system type: `ir[14:12]` sub-op, `ir[11:10]` rd, `ir[9:8]` rs.
- System sub-ops: 000 LOAD rd←mem[rs]; 001 STORE mem[rs]←rd; 010 OUT p0←rs; 011 IN rd←p1; 100 HALT; 101–111 NOP.
- Outputs are Moore, decoded from the state register. Only strobes named for a state are high; all others are 0.
- At most one bus driver (`*Out`, `PCOutEn`, `ALUOutEn`, `MDRout`) is high in any cycle.
- States and their strobes:
  - IDLE: no strobes. Next state F0.
  - F0: `PCOutEn`, `MARin`.
  - F1: `memEN`, `memRW`=1. Hold until `MFC` is sampled 1.
  - F2: `MDRreadEN`.
  - F3: `MDRout`, `IREN`, `PCInc`.
  - DEC: no strobes. Branch on the IR.
- ALU instruction: A0 (ra Out, `ALUin0`) → A1 (rb Out, `ALUin1`) → A2 (`ALUOutLatch`) → A3 (`ALUOutEn`, rd Latch) → F0.
- LOAD: L0 (rs Out, `MARin`) → L1 (`memEN`, `memRW`=1, wait `MFC`) → L2 (`MDRreadEN`) → L3 (`MDRout`, rd Latch) → F0.
- STORE: S0 (rs Out, `MARin`) → S1 (rd Out, `MDRwriteEN`) → S2 (`memEN`, `memRW`=0, wait `MFC`) → F0.
- OUT: O0 (rs Out, `p0Latch`) → F0.
- IN: I0 (`p1Out`, rd Latch) → F0.
- HALT: stays in HALT with `halted`=1 and no strobes. Only `rst` exits.
- NOP: DEC → F0.
- `opControl` is driven from `ir[14:12]` in every state, so it is stable through A0–A3.
- When ra = rb = rd, all strobes still occur in sequence. No special case.

## Timing
- Reset: `rst` sampled high puts the FSM in IDLE. All outputs are 0 in the following cycle, including `halted` and `fault`.
- Reset mid-operation takes effect at the next edge from any state, including the wait states, HALT and FAULT. No strobe completes after that edge.
- `MFC` is sampled at the clock edge. If `MFC`=1 in the first wait cycle, the wait state lasts exactly 1 cycle. `memEN` stays high for the whole wait.
- `MFC` is ignored outside F1, L1 and S2.
- Cycle counts with zero wait, measured from F0:
  - fetch + decode: 5 cycles.
  - ALU: 9. LOAD: 9. STORE: 8. OUT/IN: 6. NOP: 5.
- Each wait cycle adds 1 to these counts.
- `PCInc` is high for exactly one cycle per instruction.

## Configuration
- `CTRL_MFC_TIMEOUT_EN` defined:
  - An 8-bit wait counter clears on entry to F1, L1 or S2 and increments each wait cycle.
  - If `MFC` is still 0 after `TIMEOUT_CYCLES` wait cycles, the FSM enters FAULT: `fault`=1, all strobes 0, exit only by `rst`.
- Not defined: waits are unbounded, no counter is built, and `fault` is tied to 0.

## Test plan
- Reset: hold `rst` for 2 cycles, then release → all outputs 0 in the first cycle, then `PCOutEn`+`MARin` in the next cycle.
- ALU add: `ir`=16'h1640 (op 001, rd=r1, ra=r2, rb=r1), `MFC` always 1 →
  - `r2Out`+`ALUin0`, then `r1Out`+`ALUin1`, then `ALUOutLatch`, then `ALUOutEn`+`r1Latch`.
  - `opControl`=3'b001 throughout; back to F0 exactly 9 cycles after F0.
- LOAD with wait: `ir`=16'h8300, `MFC` held low for 3 cycles in L1 → `memEN` high for 4 cycles, then `MDRreadEN`, then `MDRout`+`r0Latch`.
- STORE: `ir`=16'h9900, `MFC`=1 → `r1Out`+`MARin`, then `r2Out`+`MDRwriteEN`, then `memEN` with `memRW`=0; 8 cycles total.
- HALT and reset: `ir`=16'hC000 → `halted`=1 for at least 20 cycles with no strobes. `rst` pulse → IDLE with `halted`=0.
- Timeout (macro on, `TIMEOUT_CYCLES`=4): `MFC` stuck 0 in F1 → `fault`=1 after 4 wait cycles and all strobes 0. With the macro off, the FSM stays in F1 indefinitely.
